// File: rtl/acc_nbit.sv
// Parametrised accumulate/scale unit: accepts one command per valid/ready handshake
// and applies its opcode to the accumulator rep+1 times, one application per cycle.
module acc_nbit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] rep,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_raw;
    logic               w_carry;
    logic [WIDTH-1:0]   w_acc_nxt;

    // Overflow handling only kicks in when the application produced a carry/borrow;
    // saturation direction follows the operation (ADD tops out, SUB bottoms out).
    function automatic logic [WIDTH-1:0] f_resolve(
        input logic [WIDTH-1:0] raw,
        input logic             carry,
        input logic             is_sub,
        input logic [1:0]       md
    );
        logic [WIDTH-1:0] res;
        res = raw;
        if (carry) begin
            case (md)
                2'b01:   res = is_sub ? '0 : '1;
                2'b10:   res = '0;
                default: res = raw;
            endcase
        end
        return res;
    endfunction

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_RUN);
    assign acc      = r_acc;
    assign cout     = r_cout;
    assign ovf      = r_ovf;
    assign done     = r_done;

    assign w_accept = in_valid & (r_state == S_IDLE);
    assign w_last   = (r_cnt == '0);

    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_b};
        w_diff  = {1'b0, r_acc} - {1'b0, r_b};
        w_raw   = r_acc;
        w_carry = 1'b0;
        case (r_op)
            OP_HOLD: w_raw = r_acc;
            OP_LOAD: w_raw = r_b;
            OP_ADD: begin
                w_raw   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow (acc < b).
                w_raw   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_AND:  w_raw = r_acc & r_b;
            OP_OR:   w_raw = r_acc | r_b;
            OP_XOR:  w_raw = r_acc ^ r_b;
            OP_CLR:  w_raw = '0;
            default: w_raw = r_acc;
        endcase
        w_acc_nxt = f_resolve(w_raw, w_carry, (r_op == OP_SUB), r_mode);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_mode <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_op   <= op;
                    r_mode <= mode;
                    r_b    <= b;
                    r_cnt  <= rep;
                    r_ovf  <= 1'b0;
                end
            end else begin
                r_acc  <= w_acc_nxt;
                r_cout <= w_carry;
                r_ovf  <= r_ovf | w_carry;
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_nbit.sv
// Directed bench for acc_nbit: a command-level arithmetic model predicts every
// cycle's outputs, backed by hand-computed literal expectations.
module tb_acc_nbit;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [1:0]   mode;
    logic [W-1:0] b;
    logic [C-1:0] rep;
    logic [W-1:0] acc;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    acc_nbit #(.WIDTH(W), .CNT_W(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .mode     (mode),
        .b        (b),
        .rep      (rep),
        .acc      (acc),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Expected outputs, maintained from the command stream.
    logic [W-1:0] exp_acc;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    endtask

    // One application of an opcode to the expected accumulator, in plain integer arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [1:0] md, input logic [W-1:0] bv);
        int unsigned a, x, r, lim;
        bit c;
        a   = exp_acc;
        x   = bv;
        lim = 1 << W;
        c   = 1'b0;
        case (o)
            3'd0: r = a;
            3'd1: r = x;
            3'd2: begin r = a + x; c = (r >= lim); end
            3'd3: begin c = (a < x); r = a + lim - x; end
            3'd4: r = a & x;
            3'd5: r = a | x;
            3'd6: r = a ^ x;
            default: r = 0;
        endcase
        r = r % lim;
        if (c) begin
            if (md == 2'd1) r = (o == 3'd2) ? lim - 1 : 0;
            else if (md == 2'd2) r = 0;
        end
        exp_acc  = r[W-1:0];
        exp_cout = c;
        exp_ovf  = exp_ovf | c;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("acc",      acc,      exp_acc);
            chk("cout",     cout,     exp_cout);
            chk("ovf",      ovf,      exp_ovf);
            chk("busy",     busy,     exp_busy);
            chk("done",     done,     exp_done);
            chk("in_ready", in_ready, exp_ready);
        end
    end

    logic [2:0]   cur_op;
    logic [1:0]   cur_mode;
    logic [W-1:0] cur_b;

    task automatic accept(input logic [2:0] o, input logic [1:0] md, input logic [W-1:0] bv,
                          input logic [C-1:0] rp, input bit noise);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        op = o; mode = md; b = bv; rep = rp;
        cur_op = o; cur_mode = md; cur_b = bv;
        @(posedge clk); #1;
        exp_busy  = 1'b1;
        exp_ready = 1'b0;
        exp_ovf   = 1'b0;
        exp_done  = 1'b0;
        // Optional junk traffic while busy: must be ignored entirely.
        in_valid = noise;
        if (noise) begin
            op = 3'b111; mode = 2'b10; b = 8'hFF; rep = 4'hF;
        end
    endtask

    task automatic step(input bit last);
        @(posedge clk); #1;
        model_apply(cur_op, cur_mode, cur_b);
        exp_done  = last;
        exp_busy  = !last;
        exp_ready = last;
        if (last) in_valid = 1'b0;
    endtask

    task automatic tail();
        @(posedge clk); #1;
        exp_done = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] o, input logic [1:0] md, input logic [W-1:0] bv,
                           input logic [C-1:0] rp, input bit noise);
        accept(o, md, bv, rp, noise);
        for (int k = 0; k <= int'(rp); k++) step(k == int'(rp));
        tail();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; op = '0; mode = '0; b = '0; rep = '0;
        exp_acc = '0; exp_cout = 0; exp_ovf = 0; exp_busy = 0; exp_done = 0; exp_ready = 1;
        #3 rst = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_acc", acc, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 1);
        #18 rst = 1'b0;

        // LOAD then repeated ADD with ignored in_valid traffic while busy.
        run_cmd(3'd1, 2'd0, 8'h05, 4'd0, 0);
        chk("load05", acc, 8'h05);
        run_cmd(3'd2, 2'd0, 8'h10, 4'd3, 1);
        chk("add10x4", acc, 8'h45);
        chk("add10x4_ovf", ovf, 0);

        // Wrap: one carry then none.
        run_cmd(3'd1, 2'd0, 8'hF0, 4'd0, 0);
        accept(3'd2, 2'd0, 8'h80, 4'd1, 0);
        step(0);
        chk("wrap_mid_acc", acc, 8'h70);
        chk("wrap_mid_cout", cout, 1);
        step(1);
        tail();
        chk("wrap_acc", acc, 8'hF0);
        chk("wrap_cout", cout, 0);
        chk("wrap_ovf", ovf, 1);

        // Saturate.
        run_cmd(3'd1, 2'd1, 8'hF0, 4'd0, 0);
        run_cmd(3'd2, 2'd1, 8'h20, 4'd2, 0);
        chk("sat_add", acc, 8'hFF);
        chk("sat_add_ovf", ovf, 1);
        run_cmd(3'd1, 2'd1, 8'h10, 4'd0, 0);
        run_cmd(3'd3, 2'd1, 8'h20, 4'd0, 0);
        chk("sat_sub", acc, 8'h00);
        chk("sat_sub_cout", cout, 1);

        // Clear-on-carry, then ovf cleared by the next command.
        run_cmd(3'd1, 2'd2, 8'hF0, 4'd0, 0);
        run_cmd(3'd2, 2'd2, 8'h20, 4'd0, 0);
        chk("coc_acc", acc, 8'h00);
        chk("coc_ovf", ovf, 1);
        run_cmd(3'd2, 2'd2, 8'h01, 4'd0, 0);
        chk("coc2_acc", acc, 8'h01);
        chk("coc2_ovf", ovf, 0);

        // Logic ops, HOLD, wrap-around SUB, mode 11 acting as wrap, CLR.
        run_cmd(3'd1, 2'd0, 8'h3C, 4'd0, 0);
        run_cmd(3'd4, 2'd0, 8'h0F, 4'd0, 0);
        chk("and", acc, 8'h0C);
        run_cmd(3'd5, 2'd0, 8'hA0, 4'd0, 0);
        chk("or", acc, 8'hAC);
        run_cmd(3'd6, 2'd0, 8'hFF, 4'd0, 0);
        chk("xor", acc, 8'h53);
        run_cmd(3'd0, 2'd0, 8'hFF, 4'd2, 0);
        chk("hold", acc, 8'h53);
        run_cmd(3'd3, 2'd0, 8'h03, 4'd0, 0);
        run_cmd(3'd3, 2'd3, 8'h51, 4'd0, 0);
        chk("sub_wrap", acc, 8'hFF);
        chk("sub_wrap_cout", cout, 1);
        run_cmd(3'd2, 2'd3, 8'h02, 4'd0, 0);
        chk("mode3_wrap", acc, 8'h01);
        run_cmd(3'd7, 2'd0, 8'h00, 4'd0, 0);
        chk("clr", acc, 8'h00);
        chk("clr_cout", cout, 0);

        // Asynchronous reset in the middle of a long command.
        run_cmd(3'd1, 2'd0, 8'hF0, 4'd0, 0);
        accept(3'd2, 2'd0, 8'h20, 4'd7, 0);
        step(0); step(0); step(0);
        chk("pre_rst_ovf", ovf, 1);
        #2 rst = 1'b1;
        #1;
        exp_acc = '0; exp_cout = 0; exp_ovf = 0; exp_busy = 0; exp_done = 0; exp_ready = 1;
        chk("arst_acc", acc, 8'h00);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        run_cmd(3'd1, 2'd0, 8'hAA, 4'd0, 0);
        chk("post_rst_load", acc, 8'hAA);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
